// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port main-memory arbiter: FSM states and port ids.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_RD_WAIT,
        ARB_RESP
    } arb_state_t;

    typedef logic arb_port_t;

    localparam arb_port_t PORT_CPU = 1'b0;
    localparam arb_port_t PORT_LD  = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between the CPU port and the loader port.
// i_ld_prio tells which side takes a conflict (starvation hit or round-robin turn).
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic [1:0] i_valid,
    input  logic       i_ld_prio,
    output logic [1:0] o_grant,
    output arb_port_t  o_winner
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        o_winner = PORT_CPU;
        o_grant  = '0;
        if (i_valid[PORT_LD] && (!i_valid[PORT_CPU] || i_ld_prio)) begin
            o_winner = PORT_LD;
        end
        o_grant[o_winner] = i_valid[o_winner];
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a single-port memory between the CPU (port 0) and the loader (port 1).
// Build option MEM_ARB_ROUND_ROBIN_EN: round-robin arbitration instead of CPU priority + starvation guard.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              rq0_valid,
    input  logic              rq0_we,
    input  logic [ADDR_W-1:0] rq0_addr,
    input  logic [DATA_W-1:0] rq0_wdata,
    output logic              rq0_ready,
    output logic              rq0_rvalid,

    input  logic              rq1_valid,
    input  logic              rq1_we,
    input  logic [ADDR_W-1:0] rq1_addr,
    input  logic [DATA_W-1:0] rq1_wdata,
    output logic              rq1_ready,
    output logic              rq1_rvalid,

    output logic [DATA_W-1:0] rdata,

    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    // RD_WAIT covers cycles T+1 .. T+RD_LAT-1 after the accept, so it ends at count RD_LAT-2.
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'((RD_LAT > 1) ? RD_LAT - 2 : 0);

    arb_state_t       r_state;
    arb_port_t        r_owner;
    logic [LAT_W-1:0] r_lat;

    logic             w_in_idle;
    logic [1:0]       w_req;
    logic [1:0]       w_grant;
    arb_port_t        w_winner;
    logic             w_accept;
    logic             w_win_we;
    logic             w_ld_prio;

    assign w_in_idle = (r_state == ARB_IDLE);
    assign w_req     = {rq1_valid, rq0_valid} & {2{w_in_idle}};

    mem_arb_pick u_pick (
        .i_valid   (w_req),
        .i_ld_prio (w_ld_prio),
        .o_grant   (w_grant),
        .o_winner  (w_winner)
    );

    assign w_accept  = |w_grant;
    assign w_win_we  = (w_winner == PORT_LD) ? rq1_we : rq0_we;

    assign rq0_ready = w_grant[PORT_CPU];
    assign rq1_ready = w_grant[PORT_LD];
    assign mem_we    = w_accept & w_win_we;
    assign mem_re    = w_accept & ~w_win_we;

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_accept) begin
            if (w_winner == PORT_LD) begin
                mem_addr  = rq1_addr;
                mem_wdata = rq1_wdata;
            end else begin
                mem_addr  = rq0_addr;
                mem_wdata = rq0_wdata;
            end
        end
    end

    assign rdata      = (r_state == ARB_RESP) ? mem_rdata : '0;
    assign rq0_rvalid = (r_state == ARB_RESP) && (r_owner == PORT_CPU);
    assign rq1_rvalid = (r_state == ARB_RESP) && (r_owner == PORT_LD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ARB_IDLE;
            r_lat   <= '0;
            r_owner <= PORT_CPU;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            case (r_state)
                ARB_IDLE: begin
                    if (mem_re) begin
                        r_owner <= w_winner;
                        r_lat   <= '0;
                        r_state <= (RD_LAT == 1) ? ARB_RESP : ARB_RD_WAIT;
                    end
                end
                ARB_RD_WAIT: begin
                    r_lat <= r_lat + LAT_W'(1);
                    if (r_lat == LAT_LAST) begin
                        r_state <= ARB_RESP;
                    end
                end
                ARB_RESP: begin
                    r_state <= ARB_IDLE;
                end
                default: begin
                    r_state <= ARB_IDLE;
                end
            endcase
        end
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Pointer starts at the loader so the CPU takes the first conflict.
    arb_port_t r_last_grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= PORT_LD;
        end else if (w_accept) begin
            r_last_grant <= w_winner;
        end
    end

    assign w_ld_prio = (r_last_grant == PORT_CPU);
`else
    localparam int               STV_W   = $clog2(STARVE_MAX + 1);
    localparam logic [STV_W-1:0] STV_LIM = STV_W'(STARVE_MAX);

    logic [STV_W-1:0] r_starve;

    // Counts consecutive IDLE cycles the loader asked and lost; frozen while a read is in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve <= '0;
        end else if (w_in_idle) begin
            if (!rq1_valid || rq1_ready) begin
                r_starve <= '0;
            end else if (r_starve != STV_LIM) begin
                r_starve <= r_starve + STV_W'(1);
            end
        end
    end

    assign w_ld_prio = (r_starve == STV_LIM);
`endif

endmodule
